// File: rtl/img_pkg.sv
// img_pkg: shared frame geometry widths, BMP row-padding helper and sequencer state encoding.
package img_pkg;
  localparam int DIM_W = 11;
  localparam int ADDR_W = 22;
  localparam int BYTES_PER_PIX = 3;
  localparam int BMP_ROW_ALIGN = 4;
  typedef enum logic [2:0] {IDLE, PREP, PIX, PAD, FIN} state_t;
  // Bytes needed to round a 24bpp row up to the 4-byte boundary; only W mod 4 matters.
  function automatic logic [1:0] row_pad(input logic [1:0] w_lsb);
    return 2'(BMP_ROW_ALIGN - BYTES_PER_PIX * int'(w_lsb));
  endfunction
endpackage

// File: rtl/raster_counter.sv
// raster_counter: column/row counters for a raster walk, row direction fixed by DOWN, with last-col/last-row flags.
module raster_counter #(
  parameter int DIM_W = img_pkg::DIM_W,
  parameter bit DOWN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             col_step,
  input  logic             row_step,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic             last_col,
  output logic             last_row
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (load) begin
      row <= DOWN ? height - 1'b1 : '0;
      col <= '0;
    end else if (row_step) begin
      row <= DOWN ? row - 1'b1 : row + 1'b1;
      col <= '0;
    end else if (col_step) begin
      col <= col + 1'b1;
    end
  end
  assign last_col = col == width - 1'b1;
  assign last_row = DOWN ? row == '0 : row == height - 1'b1;
endmodule

// File: rtl/frame_stream_ctrl.sv
// frame_stream_ctrl: walks one frame in raster order emitting read addresses, row/col tags and BMP pad beats.
// Define FRAME_STREAM_BOTTOM_UP_EN to emit rows H-1 down to 0 (BMP storage order).
module frame_stream_ctrl #(
  parameter int DIM_W = img_pkg::DIM_W,
  parameter int ADDR_W = img_pkg::ADDR_W
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  output logic              busy,
  output logic              done,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_pad,
  output logic [DIM_W-1:0]  pix_row,
  output logic [DIM_W-1:0]  pix_col,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              frame_last
);
  import img_pkg::*;
  state_t state, state_n;
  logic [DIM_W-1:0] w, h;
  logic [ADDR_W-1:0] base, first_base;
  logic [1:0] pad, pad_cnt;
  logic accept, load, col_step, row_step, row_end, last_col, last_row, pad_last;
`ifdef FRAME_STREAM_BOTTOM_UP_EN
  localparam bit DOWN = 1'b1;
  assign first_base = ADDR_W'(h - 1'b1) * ADDR_W'(w);
`else
  localparam bit DOWN = 1'b0;
  assign first_base = '0;
`endif
  raster_counter #(.DIM_W(DIM_W), .DOWN(DOWN)) u_rc (
    .clk(HCLK), .rst(HRESET), .load, .col_step, .row_step,
    .width(w), .height(h), .row(pix_row), .col(pix_col), .last_col, .last_row
  );
  assign pix_valid = state == PIX || state == PAD;
  assign pix_pad = state == PAD;
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign accept = pix_valid && pix_ready;
  assign pad_last = pad_cnt == pad - 2'd1;
  assign row_end = (state == PIX && last_col && pad == '0) || (state == PAD && pad_last);
  assign frame_last = row_end && last_row;
  assign rd_addr = base + ADDR_W'(pix_col);
  always_comb begin
    state_n = state;
    load = 1'b0;
    col_step = 1'b0;
    row_step = 1'b0;
    case (state)
      IDLE: if (start) state_n = (cfg_width == '0 || cfg_height == '0) ? FIN : PREP;
      PREP: begin
        load = 1'b1;
        state_n = PIX;
      end
      PIX, PAD: if (accept) begin
        col_step = state == PIX && !last_col;
        row_step = row_end && !last_row;
        state_n = row_end ? (last_row ? FIN : PIX) : (state == PIX && last_col) ? PAD : state;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else state <= state_n;
  end
  // Row base moves by W per row so only PREP ever needs a multiply.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      w <= '0;
      h <= '0;
      base <= '0;
      pad <= '0;
      pad_cnt <= '0;
    end else begin
      if (state == IDLE && start) begin
        w <= cfg_width;
        h <= cfg_height;
      end
      if (load) begin
        base <= first_base;
        pad <= row_pad(w[1:0]);
        pad_cnt <= '0;
      end
      if (row_step) base <= DOWN ? base - ADDR_W'(w) : base + ADDR_W'(w);
      if (accept && state == PAD) pad_cnt <= pad_last ? '0 : pad_cnt + 1'b1;
    end
  end
endmodule

// File: doc/frame_stream_ctrl.md
Name: frame_stream_ctrl

Overview:
- Frame sequencer between the frame-memory reader and `image_write`.
- On a start pulse it walks one frame in raster order, one beat per accepted cycle.
- Emits frame-memory read address, row/col tags and 24bpp BMP row-padding beats.
- Holds under valid/ready backpressure; reports busy/done to the top level.

Parameters:
- DIM_W, 11, width of width/height/row/col fields (max 2047).
- ADDR_W, 22, width of pixel address into frame memory.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame start request; sampled only in IDLE.
- cfg_width  in  DIM_W  frame width in pixels; latched on accepted start.
- cfg_height  in  DIM_W  frame height in rows; latched on accepted start.
- busy  out  1  high from cycle after accepted start until done pulse inclusive.
- done  out  1  one-cycle pulse, frame complete.
- pix_valid  out  1  beat presented.
- pix_ready  in  1  downstream accepts beat when pix_valid && pix_ready.
- pix_pad  out  1  beat is a BMP pad byte; rd_addr is don't-care.
- pix_row  out  DIM_W  row index of beat, 0 = top.
- pix_col  out  DIM_W  column index; pad beats keep the last pixel column.
- rd_addr  out  ADDR_W  pixel address = pix_row*width + pix_col.
- frame_last  out  1  high on final beat of the frame, including the final pad.

Behaviour:
- Reset: state IDLE; busy, done, pix_valid, pix_pad, frame_last = 0; pix_row, pix_col, rd_addr = 0. Asynchronous entry to IDLE mid-frame; no done pulse.
- States: IDLE, PREP, PIX, PAD, FIN.
- IDLE:
  - start=1 latches W/H and moves to PREP.
  - If W==0 or H==0, go straight to FIN; no beats are emitted.
- PREP:
  - One cycle; computes the first row index and registered row base address (row*W, single multiply).
  - Computes pad count = W[1:0] bytes, since 24bpp rows pad to 4 bytes.
  - First beat is valid 2 cycles after the start sample edge.
- PIX:
  - pix_valid=1. On accept: col++.
  - At col==W-1: go to PAD if pad!=0, else advance the row.
- PAD:
  - pix_valid=1, pix_pad=1; emits `pad` beats, then advances the row.
- Row advance:
  - col=0; base += W (top-down) or base -= W (bottom-up).
  - No bubble between rows.
  - After the last row, go to FIN.
- FIN: done=1 for one cycle, then IDLE. busy drops with IDLE.
- Backpressure: while pix_valid && !pix_ready, every beat output holds stable. pix_valid never drops without an accept.
- start while not IDLE is ignored. cfg_* changes after latch have no effect.
- rd_addr uses an incremental base+col adder. Only PREP multiplies.
- W and H are unsigned. W*H must fit ADDR_W; the caller guarantees this.

Optional Feature:
- Macro: FRAME_STREAM_BOTTOM_UP_EN.
- Defined: rows are emitted H-1 down to 0 (BMP storage order). PREP loads base=(H-1)*W.
- Undefined: rows are emitted 0 to H-1 and base starts at 0; the PREP multiplier is removed.
- Row/col tags always denote the true image coordinate.

Decomposition:
- Shared package `img_pkg`: DIM_W, ADDR_W, BYTES_PER_PIX=3, BMP_ROW_ALIGN=4, and the state enum for IDLE/PREP/PIX/PAD/FIN.
- One natural sub-module, `raster_counter`: col/row counters with wrap, up/down row direction and last-row/last-col flags. The FSM and address base stay in the top.

Test Plan:
- W=4, H=2, pix_ready=1: exactly 8 pixel beats and 0 pad beats.
  - Top-down rd_addr 0..7; first beat 2 cycles after start; done 1 cycle after beat 8.
- W=3, H=2: 6 pixel beats plus 3 pad beats per row.
  - Pad beats have pix_pad=1 and pix_col=2; frame_last on the final pad.
- W=5, H=3, BOTTOM_UP_EN defined: rows 2,1,0.
  - First rd_addr=10, last pixel rd_addr=4; 1 pad per row; 18 beats total.
- Random pix_ready (50%), W=7, H=4: all outputs stable while stalled.
  - Beat sequence identical to the pix_ready=1 run; 28 pixel + 12 pad beats.
- W=0, H=5 start: no pix_valid; done pulses in the cycle after start; busy high 1 cycle.
  - A second start while busy during a W=4, H=4 frame is ignored.
- HRESET asserted mid-row of a W=8, H=8 frame: all outputs 0 immediately, no done.
  - A fresh start afterwards replays the frame from rd_addr 0.
